// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation and tracking of
// in-flight instruction fetches so that responses to squashed fetches are dropped.
module pipe_ctrl #(
    parameter int NSTAGE = 6,
    parameter int MSTAGE = 3,
    parameter int MAXOUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              i_req,
    input  logic              i_data_ok,
    input  logic              d_req,
    input  logic              d_data_ok,
    input  logic              excep,
    input  logic              redirect,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              i_drop,
    output logic              i_busy
);

    localparam int CW = $clog2(MAXOUT + 1);
    localparam logic [CW-1:0] MAX_C  = CW'(MAXOUT);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    // Stages at or below the memory stage are squashed by an exception.
    localparam logic [NSTAGE-1:0] LOW_MASK = NSTAGE'((64'd1 << (MSTAGE + 1)) - 64'd1);

    typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_e;

    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    state_e            state_q, state_d;

    logic              fetch_wait_s;
    logic              d_wait_s;
    logic              redir_ok_s;
    logic              flush_ev_s;
    logic              dec_s;
    logic [NSTAGE-1:0] req_s;
    logic [NSTAGE-1:0] stall_base_s;
    logic [NSTAGE-1:0] flush_base_s;
    logic [NSTAGE-1:0] stall_s;
    logic [NSTAGE-1:0] flush_s;

    // Hold requests, cascaded stalls and bubbles, then exception/redirect overrides.
    always_comb begin
        fetch_wait_s = (state_q == DRAIN) | ((out_cnt_q != ZERO_C) & ~i_data_ok);
        d_wait_s     = d_req & ~d_data_ok;
        req_s        = stall_req;
        req_s[0]     = req_s[0] | fetch_wait_s;
        req_s[MSTAGE] = req_s[MSTAGE] | d_wait_s;
        flush_base_s = {NSTAGE{1'b0}};
        for (int k = 0; k < NSTAGE; k++) begin
            stall_base_s[k] = |(req_s >> k);
        end
        for (int k = 1; k < NSTAGE; k++) begin
            flush_base_s[k] = stall_base_s[k-1] & ~stall_base_s[k];
        end
        redir_ok_s = redirect & ~stall_base_s[1];
        flush_ev_s = excep | redir_ok_s;
        if (excep) begin
            stall_s = stall_base_s & ~LOW_MASK;
            flush_s = flush_base_s | LOW_MASK;
        end else if (redir_ok_s) begin
            stall_s    = stall_base_s;
            flush_s    = flush_base_s;
            stall_s[0] = 1'b0;
            flush_s[0] = 1'b1;
        end else begin
            stall_s = stall_base_s;
            flush_s = flush_base_s;
        end
    end

    // Next-state for outstanding-fetch count, stale-response count and FSM.
    always_comb begin
        dec_s = i_data_ok & (out_cnt_q != ZERO_C);
        if (i_req && i_data_ok) begin
            out_cnt_d = out_cnt_q;
        end else if (i_req && (out_cnt_q != MAX_C)) begin
            out_cnt_d = out_cnt_q + ONE_C;
        end else if (dec_s) begin
            out_cnt_d = out_cnt_q - ONE_C;
        end else begin
            out_cnt_d = out_cnt_q;
        end
        // A response arriving with the flush is itself squashed, not counted as stale.
        if (flush_ev_s) begin
            drop_cnt_d = dec_s ? (out_cnt_q - ONE_C) : out_cnt_q;
        end else if (i_data_ok && (drop_cnt_q != ZERO_C)) begin
            drop_cnt_d = drop_cnt_q - ONE_C;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        state_d = (drop_cnt_d != ZERO_C) ? DRAIN : RUN;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt_q  <= ZERO_C;
            drop_cnt_q <= ZERO_C;
            state_q    <= RUN;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
        end
    end

    assign stall  = stall_s;
    assign flush  = flush_s;
    assign i_drop = i_data_ok & (state_q == DRAIN);
    assign i_busy = (out_cnt_q == MAX_C);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with default parameters.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] stall_req;
    logic       i_req, i_data_ok, d_req, d_data_ok, excep, redirect;
    logic [5:0] stall, flush;
    logic       i_drop, i_busy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.NSTAGE(6), .MSTAGE(3), .MAXOUT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall_req (stall_req),
        .i_req     (i_req),
        .i_data_ok (i_data_ok),
        .d_req     (d_req),
        .d_data_ok (d_data_ok),
        .excep     (excep),
        .redirect  (redirect),
        .stall     (stall),
        .flush     (flush),
        .i_drop    (i_drop),
        .i_busy    (i_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; stall_req = 6'b000000;
        i_req = 1'b0; i_data_ok = 1'b0; d_req = 1'b0; d_data_ok = 1'b0;
        excep = 1'b0; redirect = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_stall", 32'(stall), 32'h00);
        check_eq("rst_flush", 32'(flush), 32'h00);
        check_eq("rst_busy",  32'(i_busy), 32'h0);
        check_eq("rst_out",   32'(dut.out_cnt_q), 32'h0);
        reset = 1'b1;
        tick();

        // Decode-stage hold request
        stall_req = 6'b000100; #1;
        check_eq("sreq_stall", 32'(stall), 32'b000111);
        check_eq("sreq_flush", 32'(flush), 32'b001000);
        stall_req = 6'b000000;
        tick();

        // Data memory wait for three cycles, then response
        d_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("dwait_stall", 32'(stall), 32'b001111);
            check_eq("dwait_flush", 32'(flush), 32'b010000);
            tick();
        end
        d_data_ok = 1'b1; #1;
        check_eq("dok_stall", 32'(stall), 32'h00);
        check_eq("dok_flush", 32'(flush), 32'h00);
        tick();
        d_req = 1'b0; d_data_ok = 1'b0;

        // Fetch requests saturate at MAXOUT
        i_req = 1'b1; #1;
        check_eq("ireq0_busy", 32'(i_busy), 32'h0);
        tick();
        check_eq("ireq1_out",  32'(dut.out_cnt_q), 32'h1);
        check_eq("ireq1_busy", 32'(i_busy), 32'h0);
        tick();
        check_eq("ireq2_out",  32'(dut.out_cnt_q), 32'h2);
        check_eq("ireq2_busy", 32'(i_busy), 32'h1);
        check_eq("ireq2_stall", 32'(stall), 32'b000001);
        tick();
        check_eq("ireq3_out",  32'(dut.out_cnt_q), 32'h2);
        i_req = 1'b0; #1;

        // Exception with two fetches in flight
        excep = 1'b1; #1;
        check_eq("exc_flush", 32'(flush), 32'b001111);
        check_eq("exc_stall", 32'(stall), 32'h00);
        tick();
        excep = 1'b0; #1;
        check_eq("exc_drop", 32'(dut.drop_cnt_q), 32'h2);
        check_eq("exc_state", 32'(dut.state_q), 32'h1);
        i_data_ok = 1'b1; #1;
        check_eq("drain1_idrop", 32'(i_drop), 32'h1);
        tick();
        #1;
        check_eq("drain2_idrop", 32'(i_drop), 32'h1);
        check_eq("drain2_drop",  32'(dut.drop_cnt_q), 32'h1);
        tick();
        i_data_ok = 1'b0; #1;
        check_eq("drain_done_state", 32'(dut.state_q), 32'h0);
        check_eq("drain_done_out",   32'(dut.out_cnt_q), 32'h0);
        i_req = 1'b1;
        tick();
        i_req = 1'b0; i_data_ok = 1'b1; #1;
        check_eq("fresh_idrop", 32'(i_drop), 32'h0);
        tick();
        i_data_ok = 1'b0;

        // Exception coinciding with the only response
        i_req = 1'b1;
        tick();
        i_req = 1'b0; #1;
        check_eq("same_out1", 32'(dut.out_cnt_q), 32'h1);
        excep = 1'b1; i_data_ok = 1'b1; #1;
        check_eq("same_idrop", 32'(i_drop), 32'h0);
        tick();
        excep = 1'b0; i_data_ok = 1'b0; #1;
        check_eq("same_drop",  32'(dut.drop_cnt_q), 32'h0);
        check_eq("same_state", 32'(dut.state_q), 32'h0);
        check_eq("same_out0",  32'(dut.out_cnt_q), 32'h0);
        check_eq("same_stall", 32'(stall), 32'h00);

        // Redirect while decode holds is ignored
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        stall_req = 6'b000010; redirect = 1'b1; #1;
        check_eq("redir_held_stall", 32'(stall), 32'b000011);
        check_eq("redir_held_flush", 32'(flush), 32'b000100);
        tick();
        check_eq("redir_held_state", 32'(dut.state_q), 32'h0);
        // Redirect taken with one fetch in flight
        stall_req = 6'b000000; #1;
        check_eq("redir_stall", 32'(stall), 32'h00);
        check_eq("redir_flush", 32'(flush), 32'b000011);
        tick();
        redirect = 1'b0; #1;
        check_eq("redir_drop",  32'(dut.drop_cnt_q), 32'h1);
        check_eq("redir_state", 32'(dut.state_q), 32'h1);
        i_data_ok = 1'b1; #1;
        check_eq("redir_idrop", 32'(i_drop), 32'h1);
        tick();
        i_data_ok = 1'b0; #1;
        check_eq("redir_done_state", 32'(dut.state_q), 32'h0);

        // Asynchronous reset in the middle of a drain
        i_req = 1'b1;
        tick();
        tick();
        i_req = 1'b0; excep = 1'b1;
        tick();
        excep = 1'b0; #1;
        check_eq("pre_rst_drop", 32'(dut.drop_cnt_q), 32'h2);
        #3;
        reset = 1'b0; #1;
        check_eq("arst_out",  32'(dut.out_cnt_q), 32'h0);
        check_eq("arst_drop", 32'(dut.drop_cnt_q), 32'h0);
        check_eq("arst_busy", 32'(i_busy), 32'h0);
        i_data_ok = 1'b1; #1;
        check_eq("arst_idrop", 32'(i_drop), 32'h0);
        i_data_ok = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        i_req = 1'b1;
        tick();
        i_req = 1'b0; i_data_ok = 1'b1; #1;
        check_eq("post_rst_idrop", 32'(i_drop), 32'h0);
        tick();
        i_data_ok = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter NSTAGE, default 6, number of pipeline stages (index 0 = fetch register, NSTAGE-1 = writeback register).
REQ-002 The block SHALL have parameter MSTAGE, default 3, index of the data-memory stage (1 <= MSTAGE <= NSTAGE-2).
REQ-003 The block SHALL have parameter MAXOUT, default 2, maximum outstanding instruction-fetch requests (>= 1).
REQ-004 The block SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port stall_req  in  NSTAGE  per-stage hold request from stage logic (e.g. load-use at decode).
REQ-007 The block SHALL have port i_req  in  1  fetch request issued and accepted this cycle.
REQ-008 The block SHALL have port i_data_ok  in  1  fetch response returns this cycle.
REQ-009 The block SHALL have port d_req  in  1  memory stage holds a load/store this cycle.
REQ-010 The block SHALL have port d_data_ok  in  1  data response this cycle.
REQ-011 The block SHALL have port excep  in  1  exception/eret committed at MSTAGE.
REQ-012 The block SHALL have port redirect  in  1  branch redirect resolved at stage 1.
REQ-013 The block SHALL have port stall  out  NSTAGE  hold stage register k.
REQ-014 The block SHALL have port flush  out  NSTAGE  load bubble into stage register k.
REQ-015 The block SHALL have port i_drop  out  1  current i_data_ok belongs to a squashed fetch; discard.
REQ-016 The block SHALL have port i_busy  out  1  outstanding == MAXOUT; fetch must not issue.

Function
REQ-017 Registered state SHALL be limited to out_cnt (outstanding fetches, 0..MAXOUT), drop_cnt (0..MAXOUT) and FSM state {RUN, DRAIN}; all outputs SHALL be combinational from state and inputs (zero latency).
REQ-018 out_cnt SHALL update as: +1 on i_req only, -1 on i_data_ok only, unchanged on both; i_req at MAXOUT and i_data_ok at 0 SHALL be ignored (saturate, no wrap).
REQ-019 i_busy SHALL equal (out_cnt == MAXOUT).
REQ-020 Flush event F = excep | (redirect & ~stall[1]).
REQ-021 On F, drop_cnt SHALL load out_cnt - i_data_ok (a response in the same cycle is squashed by the flush itself); otherwise drop_cnt SHALL decrement on i_data_ok when nonzero.
REQ-022 state SHALL be DRAIN whenever drop_cnt != 0 after update, else RUN; RUN->DRAIN only on F with remaining responses; DRAIN->RUN when last stale response arrives with no new F.
REQ-023 i_drop SHALL equal i_data_ok & (state == DRAIN).
REQ-024 fetch_wait = (state == DRAIN) | ((out_cnt != 0) & ~i_data_ok); d_wait = d_req & ~d_data_ok.
REQ-025 req[k] = stall_req[k] | (k==0 & fetch_wait) | (k==MSTAGE & d_wait).
REQ-026 stall[k] SHALL equal OR of req[j] for k <= j < NSTAGE (an older stage holds all younger).
REQ-027 flush[k] SHALL equal stall[k-1] & ~stall[k] for k >= 1; flush[0] = 0, absent F.
REQ-028 On excep: flush[k] = 1 and stall[k] = 0 for k <= MSTAGE; stages > MSTAGE keep REQ-026/027 values; excep SHALL override all stall requests at or below MSTAGE.
REQ-029 On redirect with ~stall[1] and no excep: flush[0] = 1, stall[0] = 0; redirect with stall[1] SHALL be ignored (decode re-presents it).
REQ-030 stall[k] and flush[k] SHALL never both be 1.

Reset
REQ-031 While reset = 0: out_cnt = 0, drop_cnt = 0, state = RUN, asynchronously, including mid-DRAIN; outputs then follow REQ-019..030 with zeroed state (i_busy = 0, i_drop = 0).

Verification (NSTAGE=6, MSTAGE=3, MAXOUT=2)
REQ-032 stall_req = 6'b000100, other inputs 0 -> stall = 6'b000111, flush = 6'b001000.
REQ-033 d_req = 1, d_data_ok = 0 for 3 cycles then 1 -> stall = 6'b001111, flush = 6'b010000 for 3 cycles; cycle 4 stall = 0, flush = 0.
REQ-034 i_req on 3 consecutive cycles, no responses -> out_cnt 1,2,2; i_busy = 1 from cycle 3; third i_req ignored.
REQ-035 out_cnt = 2, pulse excep -> flush = 6'b001111, stall[3:0] = 0, state DRAIN; next two i_data_ok -> i_drop = 1 each, then RUN; third i_data_ok (after new i_req) -> i_drop = 0.
REQ-036 out_cnt = 1, excep and i_data_ok same cycle -> drop_cnt = 0, state stays RUN, out_cnt = 0.
REQ-037 Assert reset = 0 while DRAIN with drop_cnt = 2 -> same cycle out_cnt = 0, drop_cnt = 0, i_drop = 0; after release, i_data_ok not dropped.
